// File: rtl/datapath_defs.sv
// Shared control/datapath definitions: state encodings, opcodes, aluop codes, mux selects.
package datapath_defs;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        IEXEC  = 4'd8,
        IWB    = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [3:0] OP_RARITH = 4'd0;
    localparam logic [3:0] OP_RLOGIC = 4'd1;
    localparam logic [3:0] OP_ADDI   = 4'd2;
    localparam logic [3:0] OP_ANDI   = 4'd3;
    localparam logic [3:0] OP_ORI    = 4'd4;
    localparam logic [3:0] OP_SLTI   = 4'd5;
    localparam logic [3:0] OP_LW     = 4'd6;
    localparam logic [3:0] OP_SW     = 4'd7;
    localparam logic [3:0] OP_BEQ    = 4'd8;
    localparam logic [3:0] OP_J      = 4'd9;

    localparam logic [2:0] ALU_RARITH = 3'b000;
    localparam logic [2:0] ALU_RLOGIC = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_SUB    = 3'b011;
    localparam logic [2:0] ALU_OR     = 3'b100;
    localparam logic [2:0] ALU_AND    = 3'b101;
    localparam logic [2:0] ALU_SLT    = 3'b110;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] aluop;
        logic       illegal;
    } ctrl_t;

    function automatic logic [2:0] imm_aluop(input logic [3:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational strobe decode from current state, live/latched opcode and mem_ready.
module main_ctrl_outdec
    import datapath_defs::*;
(
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic [3:0] op_latched,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl       = '0;
        ctrl.aluop = ALU_ADD;
        case (state)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_source = PCS_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
                // IR only becomes valid this cycle, so use the live opcode
                ctrl.illegal   = (opcode > OP_J);
            end
            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            REXEC, RWB: begin
                ctrl.aluop = (op_latched == OP_RLOGIC) ? ALU_RLOGIC : ALU_RARITH;
                if (state == REXEC) begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                end else begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
            end
            IEXEC, IWB: begin
                ctrl.aluop = imm_aluop(op_latched);
                if (state == IEXEC) begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                end else begin
                    ctrl.reg_write = 1'b1;
                end
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.aluop         = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
            end
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/main_controller.sv
// Multicycle main control FSM: state register, latched opcode, retired-instruction counter.
module main_controller
    import datapath_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       aluop,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t     cur, nxt;
    logic [3:0] op_q;
    logic       retire;
    ctrl_t      dec, ctrl;

    // The zero flag qualifies pc_write_cond in the datapath, not here
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur     <= FETCH;
            op_q    <= '0;
            retired <= '0;
        end else begin
            cur <= nxt;
            if (cur == DECODE)
                op_q <= opcode;
            if (retire)
                retired <= retired + CNT_ONE;
        end
    end

    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RARITH, OP_RLOGIC:             nxt = REXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = IEXEC;
                    OP_LW, OP_SW:                     nxt = MEMADR;
                    OP_BEQ:                           nxt = BRANCH;
                    OP_J:                             nxt = JUMP;
                    default:                          nxt = FETCH;
                endcase
            end
            MEMADR: nxt = (op_q == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
            MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
            REXEC:  nxt = RWB;
            IEXEC:  nxt = IWB;
            default: nxt = FETCH;
        endcase
    end

    always_comb begin
        case (cur)
            MEMWB, MEMWR, RWB, IWB, BRANCH, JUMP: retire = (nxt == FETCH);
            default:                             retire = 1'b0;
        endcase
    end

    main_ctrl_outdec u_outdec (
        .state      (cur),
        .opcode     (opcode),
        .op_latched (op_q),
        .mem_ready  (mem_ready),
        .ctrl       (dec)
    );

    // Reset forces every strobe low while leaving the aluop default visible
    always_comb begin
        ctrl = dec;
        if (rst) begin
            ctrl       = '0;
            ctrl.aluop = dec.aluop;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign pc_source     = ctrl.pc_source;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign ir_write      = ctrl.ir_write;
    assign reg_dst       = ctrl.reg_dst;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_write     = ctrl.reg_write;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign aluop         = ctrl.aluop;
    assign illegal       = ctrl.illegal;
    assign state         = cur;

endmodule

// File: tb/tb_main_controller.sv
// Scoreboard bench for main_controller: per-cycle expected state/strobes/retired queued then compared.
module tb_main_controller;

    localparam int CW = 8;

    localparam logic [17:0] PCW  = 18'h20000;
    localparam logic [17:0] PCWC = 18'h10000;
    localparam logic [17:0] IORD = 18'h02000;
    localparam logic [17:0] MR   = 18'h01000;
    localparam logic [17:0] MW   = 18'h00800;
    localparam logic [17:0] IRW  = 18'h00400;
    localparam logic [17:0] RD   = 18'h00200;
    localparam logic [17:0] M2R  = 18'h00100;
    localparam logic [17:0] RW   = 18'h00080;
    localparam logic [17:0] SA   = 18'h00040;
    localparam logic [17:0] ILL  = 18'h00001;
    localparam logic [17:0] AOP_MASK = 18'h0000E;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    opcode;
    logic          zero;
    logic          mem_ready;
    logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic          reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    logic [1:0]    pc_source, alu_src_b;
    logic [2:0]    aluop;
    logic [3:0]    state;
    logic [CW-1:0] retired;
    logic [17:0]   obs;

    typedef struct {
        logic [3:0]    st;
        logic [17:0]   vec;
        logic [CW-1:0] ret;
        logic          rdy;
    } rec_t;

    rec_t          q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] mret;

    main_controller #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .aluop(aluop), .illegal(illegal),
        .state(state), .retired(retired)
    );

    assign obs = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, aluop, illegal};

    always #5 clk = ~clk;

    function automatic logic [17:0] aop(input logic [2:0] a);
        return {14'b0, a, 1'b0};
    endfunction

    function automatic logic [17:0] sb(input logic [1:0] s);
        return {12'b0, s, 4'b0};
    endfunction

    function automatic logic [17:0] pcs(input logic [1:0] p);
        return {2'b0, p, 14'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic [17:0] vec, input logic rdy);
        rec_t r;
        r.st = st; r.vec = vec; r.ret = mret; r.rdy = rdy;
        q.push_back(r);
    endtask

    // Entered at posedge+1; each record drives one cycle and is compared at the negedge.
    task automatic drain();
        while (q.size() > 0) begin
            rec_t r;
            r = q.pop_front();
            mem_ready = r.rdy;
            zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("state", 32'(state), 32'(r.st));
            check("strobes", 32'(obs), 32'(r.vec));
            check("retired", 32'(retired), 32'(r.ret));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push_fetch(input int stalls);
        for (int i = 0; i < stalls; i++)
            push(4'd0, MR | sb(2'b01) | aop(3'b010), 1'b0);
        push(4'd0, MR | IRW | PCW | sb(2'b01) | aop(3'b010), 1'b1);
    endtask

    task automatic run_instr(input logic [3:0] op, input int fstall, input int mstall);
        logic [2:0] a;
        opcode = op;
        push_fetch(fstall);
        push(4'd1, sb(2'b11) | aop(3'b010) | ((op >= 4'd10) ? ILL : 18'h0), rnd());
        if (op >= 4'd10) begin
            drain();
            return;
        end
        case (op)
            4'd0, 4'd1: begin
                a = (op == 4'd1) ? 3'b001 : 3'b000;
                push(4'd6, SA | sb(2'b00) | aop(a), rnd());
                push(4'd7, RW | RD | aop(a), rnd());
            end
            4'd2, 4'd3, 4'd4, 4'd5: begin
                a = (op == 4'd3) ? 3'b101 : (op == 4'd4) ? 3'b100 : (op == 4'd5) ? 3'b110 : 3'b010;
                push(4'd8, SA | sb(2'b10) | aop(a), rnd());
                push(4'd9, RW | aop(a), rnd());
            end
            4'd6: begin
                push(4'd2, SA | sb(2'b10) | aop(3'b010), rnd());
                for (int i = 0; i < mstall; i++)
                    push(4'd3, MR | IORD | aop(3'b010), 1'b0);
                push(4'd3, MR | IORD | aop(3'b010), 1'b1);
                push(4'd4, RW | M2R | aop(3'b010), rnd());
            end
            4'd7: begin
                push(4'd2, SA | sb(2'b10) | aop(3'b010), rnd());
                for (int i = 0; i < mstall; i++)
                    push(4'd5, MW | IORD | aop(3'b010), 1'b0);
                push(4'd5, MW | IORD | aop(3'b010), 1'b1);
            end
            4'd8: push(4'd10, SA | sb(2'b00) | aop(3'b011) | PCWC | pcs(2'b01), rnd());
            default: push(4'd11, PCW | pcs(2'b10) | aop(3'b010), rnd());
        endcase
        drain();
        mret = mret + CW'(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 4'd0;
        zero = 1'b0;
        mret = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobes", 32'(obs & ~AOP_MASK), 32'd0);
        check("rst_retired", 32'(retired), 32'd0);
        rst = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        run_instr(4'd0, 0, 0);
        run_instr(4'd6, 3, 2);
        run_instr(4'd1, 1, 0);
        run_instr(4'd2, 0, 0);
        run_instr(4'd3, 0, 0);
        run_instr(4'd4, 2, 0);
        run_instr(4'd5, 0, 0);
        run_instr(4'd7, 0, 1);
        run_instr(4'd8, 0, 0);
        run_instr(4'd9, 0, 0);
        run_instr(4'hC, 1, 0);
        run_instr(4'hF, 0, 0);
        run_instr(4'd6, 0, 0);

        // Reset arriving mid-store: SW parked in MEMWR waiting on memory
        opcode = 4'd7;
        push_fetch(0);
        push(4'd1, sb(2'b11) | aop(3'b010), 1'b0);
        push(4'd2, SA | sb(2'b10) | aop(3'b010), 1'b0);
        push(4'd5, MW | IORD | aop(3'b010), 1'b0);
        drain();
        mem_ready = 1'b0;
        check("memwr_before_rst", 32'(mem_write), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_state", 32'(state), 32'd0);
        check("rst_mid_strobes", 32'(obs & ~AOP_MASK), 32'd0);
        check("rst_mid_retired", 32'(retired), 32'd0);
        @(negedge clk);
        check("rst_hold_strobes", 32'(obs & ~AOP_MASK), 32'd0);
        rst = 1'b0;
        mret = '0;
        @(posedge clk);
        #1;
        run_instr(4'd9, 0, 0);

        // Counter wrap: retire enough jumps to roll past all-ones
        for (int n = 0; n < (1 << CW); n++)
            run_instr(4'd9, int'(rnd()), 0);
        push(4'd0, MR | sb(2'b01) | aop(3'b010), 1'b0);
        drain();
        check("wrap_retired", 32'(retired), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
